// File: rtl/reg_dump_reader.sv
// Debug read-port master: walks the core's extra register-file read select and
// streams one frame (PC, r0..r(NUM_REGS-1)) over a valid/ready word interface.
module reg_dump_reader #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [31:0] out_data,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_SEL = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LOAD} state_t;

  state_t      state, state_nxt;
  logic [4:0]  reg_sel_nxt;
  logic [31:0] out_data_nxt;
  logic [5:0]  out_index_nxt;
  logic        out_last_nxt;
  logic        out_valid_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    reg_sel_nxt   = reg_sel;
    out_data_nxt  = out_data;
    out_index_nxt = out_index;
    out_last_nxt  = out_last;
    out_valid_nxt = out_valid;
    busy_nxt      = busy;
    done_nxt      = done;
    unique case (state)
      IDLE: begin
        done_nxt = 1'b0;
        if (start) begin
          out_data_nxt  = pc_in;
          out_index_nxt = 6'd0;
          out_last_nxt  = 1'b0;
          reg_sel_nxt   = 5'd0;
          out_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          if (out_last) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        // reg_sel has been stable for the whole SEND phase, so reg_data is settled here
        out_data_nxt  = reg_data;
        out_index_nxt = {1'b0, reg_sel} + 6'd1;
        out_last_nxt  = (reg_sel == LAST_SEL);
        reg_sel_nxt   = reg_sel + 5'd1;
        out_valid_nxt = 1'b1;
        state_nxt     = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_sel   <= 5'd0;
      out_data  <= 32'd0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      reg_sel   <= reg_sel_nxt;
      out_data  <= out_data_nxt;
      out_index <= out_index_nxt;
      out_last  <= out_last_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
